// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Watches NUM_CH sampled status lines, turns every level transition into a
//   pending event (one slot per channel, newest level wins) and hands the
//   events out one at a time through a round-robin arbitrated valid/ready port.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   enable     1 = edge trackers run, 0 = trackers held in INIT (no new events)
//   in_bits    sampled input lines, one per channel
//   evt_valid  presented event is valid
//   evt_ready  consumer accepts the presented event when valid && ready
//   evt_chan   channel index of the presented event
//   evt_level  level after the edge (1 = rising, 0 = falling)
//   ovr_flags  sticky per-channel overrun flags
//   clr_ovr    one-cycle pulse clearing all overrun flags
//   evt_count  accepted-event counter, saturating at all-ones
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         in_bits,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(NUM_CH)-1:0] evt_chan,
  output logic                      evt_level,
  output logic [NUM_CH-1:0]         ovr_flags,
  input  logic                      clr_ovr,
  output logic [CNT_W-1:0]          evt_count
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } trk_state_t;

  logic [NUM_CH-1:0] w_edge;
  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_plvl;
  logic [NUM_CH-1:0] r_ovr;
  logic [CH_W-1:0]   r_rr;
  logic [CH_W-1:0]   r_chan;
  logic              r_valid;
  logic              r_level;
  logic [CNT_W-1:0]  r_count;
  logic              w_free;
  logic              w_accept;
  logic              w_found;
  logic [CH_W-1:0]   w_winner;

  // Output register may take a new event when empty or being consumed now.
  assign w_free   = !r_valid || evt_ready;
  assign w_accept = r_valid && evt_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_trk
      trk_state_t r_state;

      // INIT only records history: the first sample never makes an event.
      always_ff @(posedge clk) begin
        if (rst || !enable) begin
          r_state <= S_INIT;
        end else begin
          case (r_state)
            S_INIT:  r_state <= in_bits[gi] ? S_HIGH : S_LOW;
            S_LOW:   if (in_bits[gi])  r_state <= S_HIGH;
            S_HIGH:  if (!in_bits[gi]) r_state <= S_LOW;
            default: r_state <= S_INIT;
          endcase
        end
      end

      assign w_edge[gi]  = enable &&
                           (((r_state == S_LOW)  &&  in_bits[gi]) ||
                            ((r_state == S_HIGH) && !in_bits[gi]));
      assign w_grant[gi] = w_free && w_found && (w_winner == CH_W'(gi));
    end
  endgenerate

  // Round-robin search: scan offsets high to low so the smallest offset from
  // the pointer is the last assignment and therefore the winner.
  always_comb begin
    logic [CH_W:0] sum;
    w_found  = 1'b0;
    w_winner = '0;
    sum      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      sum = {1'b0, r_rr} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH)) begin
        sum = sum - (CH_W+1)'(NUM_CH);
      end
      if (r_pend[sum[CH_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = sum[CH_W-1:0];
      end
    end
  end

  // Pending slots: a new edge always (re)arms the slot with the newest level;
  // it only counts as an overrun if the old content was not just handed out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_plvl <= '0;
      r_ovr  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_edge[i]) begin
          r_pend[i] <= 1'b1;
          r_plvl[i] <= in_bits[i];
        end else if (w_grant[i]) begin
          r_pend[i] <= 1'b0;
        end
        // A fresh overrun beats a simultaneous clear.
        if (w_edge[i] && r_pend[i] && !w_grant[i]) begin
          r_ovr[i] <= 1'b1;
        end else if (clr_ovr) begin
          r_ovr[i] <= 1'b0;
        end
      end
    end
  end

  // Presented-event register, rr pointer and accepted counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_level <= 1'b0;
      r_rr    <= '0;
      r_count <= '0;
    end else begin
      if (w_free) begin
        if (w_found) begin
          r_valid <= 1'b1;
          r_chan  <= w_winner;
          r_level <= r_plvl[w_winner];
          r_rr    <= (w_winner == CH_W'(NUM_CH - 1)) ? '0 : w_winner + CH_W'(1);
        end else begin
          r_valid <= 1'b0;
        end
      end
      if (w_accept && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_chan  = r_chan;
  assign evt_level = r_level;
  assign ovr_flags = r_ovr;
  assign evt_count = r_count;

endmodule
